// File: rtl/sw_debounce3_if.sv
// Switch-conditioning bus between the raw switch pins and the LED decoder top level.
// The master drives the raw levels; the slave (debouncer) returns the conditioned code.
interface sw_debounce3_if;
    logic [2:0] sw_in;
    logic [2:0] sw_out;
    logic       sw_changed;
    logic       sw_valid;

    modport master (output sw_in, input sw_out, input sw_changed, input sw_valid);
    modport slave  (input sw_in, output sw_out, output sw_changed, output sw_valid);
endinterface

// File: rtl/sw_debounce3.sv
// Two-flop synchroniser plus independent per-switch debounce for the 3-bit decoder select,
// with a one-cycle change strobe and a startup-valid flag.
module sw_db_lane #(
    parameter int DB_CYCLES = 8,
    parameter int CNT_W     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic q,
    output logic flip
);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DB_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // High on the edge at which q is about to take the new level.
    assign flip = (din != q) && (cnt == TERM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            q   <= 1'b0;
        end else if (din == q) begin
            cnt <= '0;
        end else if (cnt == TERM) begin
            q   <= din;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

module sw_debounce3 #(
    parameter int DB_CYCLES = 240000,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic           clk,
    input  logic           rst,
    sw_debounce3_if.slave  sw
);
    localparam int NUM_LANES = 3;
    localparam logic [CNT_W-1:0] ST_PRE  = CNT_W'(DB_CYCLES);
    localparam logic [CNT_W-1:0] ST_TERM = CNT_W'(DB_CYCLES + 1);

    if (DB_CYCLES < 2) begin : g_chk_db
        $error("sw_debounce3: DB_CYCLES must be 2 or greater");
    end
    if ((DB_CYCLES + 1) > ((1 << CNT_W) - 1)) begin : g_chk_w
        $error("sw_debounce3: CNT_W too narrow to hold DB_CYCLES+1");
    end

    logic [NUM_LANES-1:0] sync1, sync2;
    logic [NUM_LANES-1:0] q, flip;
    logic                 changed_q;
    logic                 valid_q;
    logic [CNT_W-1:0]     st_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sw.sw_in;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        sw_db_lane #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_lane (
            .clk  (clk),
            .rst  (rst),
            .din  (sync2[i]),
            .q    (q[i]),
            .flip (flip[i])
        );
    end

    // Registered alongside q so the strobe lines up with the first cycle of the new code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) changed_q <= 1'b0;
        else     changed_q <= |flip;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_cnt  <= '0;
            valid_q <= 1'b0;
        end else if (st_cnt != ST_TERM) begin
            st_cnt <= st_cnt + 1'b1;
            if (st_cnt == ST_PRE) valid_q <= 1'b1;
        end
    end

    assign sw.sw_out     = q;
    assign sw.sw_changed = changed_q;
    assign sw.sw_valid   = valid_q;
endmodule

// File: tb/tb_sw_debounce3.sv
// Directed self-checking bench for sw_debounce3 with DB_CYCLES = 8.
module tb_sw_debounce3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    sw_debounce3_if sif();

    sw_debounce3 #(.DB_CYCLES(8), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input logic [2:0] v);
        sif.sw_in = v;
        repeat (14) tick();
    endtask

    task automatic test_reset();
        logic [2:0] e_out;
        rst = 1'b1;
        sif.sw_in = 3'b101;
        repeat (3) tick();
        n_chk++;
        if (sif.sw_out !== 3'b000) begin n_fail++; $display("FAIL reset_out: got %b expected 000", sif.sw_out); end
        n_chk++;
        if (sif.sw_changed !== 1'b0) begin n_fail++; $display("FAIL reset_chg: got %b expected 0", sif.sw_changed); end
        n_chk++;
        if (sif.sw_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", sif.sw_valid); end
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            e_out = (k >= 10) ? 3'b101 : 3'b000;
            n_chk++;
            if (sif.sw_out !== e_out) begin n_fail++; $display("FAIL rel_out k=%0d: got %b expected %b", k, sif.sw_out, e_out); end
            n_chk++;
            if (sif.sw_changed !== (k == 10)) begin n_fail++; $display("FAIL rel_chg k=%0d: got %b expected %b", k, sif.sw_changed, (k == 10)); end
            n_chk++;
            if (sif.sw_valid !== (k >= 9)) begin n_fail++; $display("FAIL rel_valid k=%0d: got %b expected %b", k, sif.sw_valid, (k >= 9)); end
        end
    endtask

    task automatic test_clean_change();
        logic [2:0] e_out;
        settle(3'b000);
        sif.sw_in = 3'b011;
        for (int k = 1; k <= 12; k++) begin
            tick();
            e_out = (k >= 10) ? 3'b011 : 3'b000;
            n_chk++;
            if (sif.sw_out !== e_out) begin n_fail++; $display("FAIL clean_out k=%0d: got %b expected %b", k, sif.sw_out, e_out); end
            n_chk++;
            if (sif.sw_changed !== (k == 10)) begin n_fail++; $display("FAIL clean_chg k=%0d: got %b expected %b", k, sif.sw_changed, (k == 10)); end
            n_chk++;
            if (sif.sw_valid !== 1'b1) begin n_fail++; $display("FAIL clean_valid k=%0d: got %b expected 1", k, sif.sw_valid); end
        end
    endtask

    task automatic test_glitch();
        logic [2:0] e_out;
        // 7-cycle pulse on bit 2: must be swallowed
        sif.sw_in = 3'b111;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 7) sif.sw_in = 3'b011;
            n_chk++;
            if (sif.sw_out !== 3'b011) begin n_fail++; $display("FAIL glitch7_out k=%0d: got %b expected 011", k, sif.sw_out); end
            n_chk++;
            if (sif.sw_changed !== 1'b0) begin n_fail++; $display("FAIL glitch7_chg k=%0d: got %b expected 0", k, sif.sw_changed); end
        end
        // 8-cycle pulse: just long enough
        sif.sw_in = 3'b111;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 8) sif.sw_in = 3'b011;
            e_out = (k >= 10) ? 3'b111 : 3'b011;
            n_chk++;
            if (sif.sw_out !== e_out) begin n_fail++; $display("FAIL glitch8_out k=%0d: got %b expected %b", k, sif.sw_out, e_out); end
            n_chk++;
            if (sif.sw_changed !== (k == 10)) begin n_fail++; $display("FAIL glitch8_chg k=%0d: got %b expected %b", k, sif.sw_changed, (k == 10)); end
        end
    endtask

    task automatic test_bounce();
        int runs [4] = '{3, 2, 4, 1};
        logic [2:0] e_out;
        settle(3'b000);
        for (int r = 0; r < 4; r++) begin
            sif.sw_in = (r % 2 == 0) ? 3'b001 : 3'b000;
            for (int c = 0; c < runs[r]; c++) begin
                tick();
                n_chk++;
                if (sif.sw_out !== 3'b000 || sif.sw_changed !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bounce_hold r=%0d: got out=%b chg=%b expected out=000 chg=0", r, sif.sw_out, sif.sw_changed);
                end
            end
        end
        sif.sw_in = 3'b001;
        for (int k = 1; k <= 12; k++) begin
            tick();
            e_out = (k >= 10) ? 3'b001 : 3'b000;
            n_chk++;
            if (sif.sw_out !== e_out) begin n_fail++; $display("FAIL bounce_out k=%0d: got %b expected %b", k, sif.sw_out, e_out); end
            n_chk++;
            if (sif.sw_changed !== (k == 10)) begin n_fail++; $display("FAIL bounce_chg k=%0d: got %b expected %b", k, sif.sw_changed, (k == 10)); end
        end
    endtask

    task automatic test_staggered();
        logic [2:0] e_out;
        settle(3'b000);
        sif.sw_in = 3'b001;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 3) sif.sw_in = 3'b011;
            e_out = {1'b0, (k >= 13), (k >= 10)};
            n_chk++;
            if (sif.sw_out !== e_out) begin n_fail++; $display("FAIL stagger_out k=%0d: got %b expected %b", k, sif.sw_out, e_out); end
            n_chk++;
            if (sif.sw_changed !== (k == 10 || k == 13)) begin
                n_fail++;
                $display("FAIL stagger_chg k=%0d: got %b expected %b", k, sif.sw_changed, (k == 10 || k == 13));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] e_out;
        settle(3'b000);
        sif.sw_in = 3'b111;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        n_chk++;
        if (sif.sw_out !== 3'b000 || sif.sw_changed !== 1'b0 || sif.sw_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: got out=%b chg=%b valid=%b expected 000/0/0", sif.sw_out, sif.sw_changed, sif.sw_valid);
        end
        repeat (2) tick();
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            e_out = (k >= 10) ? 3'b111 : 3'b000;
            n_chk++;
            if (sif.sw_out !== e_out) begin n_fail++; $display("FAIL midrst_out k=%0d: got %b expected %b", k, sif.sw_out, e_out); end
            n_chk++;
            if (sif.sw_changed !== (k == 10)) begin n_fail++; $display("FAIL midrst_chg k=%0d: got %b expected %b", k, sif.sw_changed, (k == 10)); end
            n_chk++;
            if (sif.sw_valid !== (k >= 9)) begin n_fail++; $display("FAIL midrst_valid k=%0d: got %b expected %b", k, sif.sw_valid, (k >= 9)); end
        end
    endtask

    initial begin
        sif.sw_in = 3'b000;
        test_reset();
        test_clean_change();
        test_glitch();
        test_bounce();
        test_staggered();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
